// File: rtl/reglog_bank.sv
// reglog_bank: DEPTH x DATA_W register bank with one byte-enabled write port,
// two registered, write-first bypassed read ports (A, B) and a sequential
// clear-sweep FSM that zeroes one entry per cycle while busy is high.
// Optional build macro: REGLOG_PARITY_EN adds per-lane even parity storage,
// a parity-inject input and per-port parity-error outputs.
module reglog_bank #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3,
  localparam int unsigned BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_err
`ifdef REGLOG_PARITY_EN
  ,
  input  logic              par_inj,
  output logic              rd_perr_a,
  output logic              rd_perr_b
`endif
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly (unsigned).
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next;
  logic              sweeping;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_in_range;
  logic              wr_ok;

  logic [1:0]        rd_en_v;
  logic [ADDR_W-1:0] rd_addr_v [2];
  logic [DATA_W-1:0] rd_word   [2];
  logic [DATA_W-1:0] rd_data_q [2];
  logic [1:0]        rd_valid_q;

`ifdef REGLOG_PARITY_EN
  logic [BE_W-1:0]   par_mem [DEPTH];
  logic [BE_W-1:0]   rd_par  [2];
  logic [1:0]        rd_perr_q;
`endif

  function automatic logic [BE_W-1:0] lane_parity(input logic [DATA_W-1:0] d);
    logic [BE_W-1:0] p;
    p = '0;
    for (int unsigned k = 0; k < BE_W; k++) p[k] = ^d[8*k +: 8];
    return p;
  endfunction

  assign sweeping    = (state == SWEEP);
  assign busy        = sweeping;
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign wr_ok       = wr_en && !sweeping && wr_in_range;

  assign rd_en_v      = {rd_en_b, rd_en_a};
  assign rd_addr_v[0] = rd_addr_a;
  assign rd_addr_v[1] = rd_addr_b;
  assign rd_data_a    = rd_data_q[0];
  assign rd_data_b    = rd_data_q[1];
  assign rd_valid_a   = rd_valid_q[0];
  assign rd_valid_b   = rd_valid_q[1];
`ifdef REGLOG_PARITY_EN
  assign rd_perr_a    = rd_perr_q[0];
  assign rd_perr_b    = rd_perr_q[1];
`endif

  // Clear-sweep state and pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Sweep next-state: start on clr_req from IDLE, leave after the last entry.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_next = SWEEP;
          ptr_next   = '0;
        end
      end
      SWEEP: begin
        if (ptr == PTR_LAST) begin
          state_next = IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  // Array update: sweep clears one entry; otherwise accepted writes merge lanes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
`ifdef REGLOG_PARITY_EN
        par_mem[i] <= '0;
`endif
      end
    end else if (sweeping) begin
      mem[ptr] <= '0;
`ifdef REGLOG_PARITY_EN
      par_mem[ptr] <= '0;
`endif
    end else if (wr_ok) begin
      for (int unsigned k = 0; k < BE_W; k++) begin
        if (wr_be[k]) begin
          mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
`ifdef REGLOG_PARITY_EN
          par_mem[wr_addr][k] <= (^wr_data[8*k +: 8]) ^ par_inj;
`endif
        end
      end
    end
  end

  // Read-word selection per port: out-of-range and entry-under-clear give 0,
  // a same-cycle accepted write is merged lane by lane (write-first).
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rd_word[p] = '0;
`ifdef REGLOG_PARITY_EN
      rd_par[p] = '0;
`endif
      if (({1'b0, rd_addr_v[p]} < DEPTH_L) && !(sweeping && (ptr == rd_addr_v[p]))) begin
        rd_word[p] = mem[rd_addr_v[p]];
`ifdef REGLOG_PARITY_EN
        rd_par[p] = par_mem[rd_addr_v[p]];
`endif
        if (wr_ok && (wr_addr == rd_addr_v[p])) begin
          for (int unsigned k = 0; k < BE_W; k++) begin
            if (wr_be[k]) begin
              rd_word[p][8*k +: 8] = wr_data[8*k +: 8];
`ifdef REGLOG_PARITY_EN
              rd_par[p][k] = (^wr_data[8*k +: 8]) ^ par_inj;
`endif
            end
          end
        end
      end
    end
  end

  // Registered read outputs; data holds while a port is not reading.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= '0;
      for (int unsigned p = 0; p < 2; p++) rd_data_q[p] <= '0;
`ifdef REGLOG_PARITY_EN
      rd_perr_q <= '0;
`endif
    end else begin
      rd_valid_q <= rd_en_v;
      for (int unsigned p = 0; p < 2; p++) begin
        if (rd_en_v[p]) rd_data_q[p] <= rd_word[p];
`ifdef REGLOG_PARITY_EN
        rd_perr_q[p] <= rd_en_v[p] && (|(lane_parity(rd_word[p]) ^ rd_par[p]));
`endif
      end
    end
  end

  // Rejected-write pulse: busy or out-of-range request, one cycle late.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_err <= 1'b0;
    else        wr_err <= wr_en && (sweeping || !wr_in_range);
  end

endmodule

// File: tb/tb_reglog_bank.sv
// tb_reglog_bank: directed self-checking bench for reglog_bank (DEPTH=8 main
// instance plus a DEPTH=6 instance for out-of-range addressing).
module tb_reglog_bank;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        rd_en_a;
  logic [2:0]  rd_addr_a;
  logic [15:0] rd_data_a;
  logic        rd_valid_a;
  logic        rd_en_b;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_b;
  logic        rd_valid_b;
  logic        clr_req;
  logic        busy;
  logic        wr_err;

  logic        s6_wr_en;
  logic [2:0]  s6_wr_addr;
  logic [15:0] s6_wr_data;
  logic        s6_rd_en;
  logic [2:0]  s6_rd_addr;
  logic [15:0] s6_rd_data;
  logic        s6_rd_valid;
  logic [15:0] s6_rd_data_b;
  logic        s6_rd_valid_b;
  logic        s6_busy;
  logic        s6_wr_err;

`ifdef REGLOG_PARITY_EN
  logic        par_inj;
  logic        rd_perr_a;
  logic        rd_perr_b;
  logic        s6_perr_a;
  logic        s6_perr_b;
`endif

  int checks = 0;
  int errors = 0;
  int busy_cnt;

  reglog_bank #(.DATA_W(16), .DEPTH(8), .ADDR_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_be      (wr_be),
    .rd_en_a    (rd_en_a),
    .rd_addr_a  (rd_addr_a),
    .rd_data_a  (rd_data_a),
    .rd_valid_a (rd_valid_a),
    .rd_en_b    (rd_en_b),
    .rd_addr_b  (rd_addr_b),
    .rd_data_b  (rd_data_b),
    .rd_valid_b (rd_valid_b),
    .clr_req    (clr_req),
    .busy       (busy),
    .wr_err     (wr_err)
`ifdef REGLOG_PARITY_EN
    ,
    .par_inj    (par_inj),
    .rd_perr_a  (rd_perr_a),
    .rd_perr_b  (rd_perr_b)
`endif
  );

  reglog_bank #(.DATA_W(16), .DEPTH(6), .ADDR_W(3)) dut6 (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (s6_wr_en),
    .wr_addr    (s6_wr_addr),
    .wr_data    (s6_wr_data),
    .wr_be      (2'b11),
    .rd_en_a    (s6_rd_en),
    .rd_addr_a  (s6_rd_addr),
    .rd_data_a  (s6_rd_data),
    .rd_valid_a (s6_rd_valid),
    .rd_en_b    (1'b0),
    .rd_addr_b  (3'd0),
    .rd_data_b  (s6_rd_data_b),
    .rd_valid_b (s6_rd_valid_b),
    .clr_req    (1'b0),
    .busy       (s6_busy),
    .wr_err     (s6_wr_err)
`ifdef REGLOG_PARITY_EN
    ,
    .par_inj    (1'b0),
    .rd_perr_a  (s6_perr_a),
    .rd_perr_b  (s6_perr_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_be = 2'b00; wr_addr = '0; wr_data = '0;
    rd_en_a = 1'b0; rd_en_b = 1'b0; clr_req = 1'b0;
    s6_wr_en = 1'b0; s6_rd_en = 1'b0;
  endtask

  task automatic write8(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_a(input logic [2:0] a);
    rd_en_a = 1'b1; rd_addr_a = a;
    tick();
    rd_en_a = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0; s6_wr_addr = '0; s6_wr_data = '0; s6_rd_addr = '0;
`ifdef REGLOG_PARITY_EN
    par_inj = 1'b0;
`endif
    idle_inputs();
    #12;
    check("reset_rd_data_a", 32'(rd_data_a), 32'h0);
    check("reset_rd_valid_a", 32'(rd_valid_a), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_wr_err", 32'(wr_err), 32'h0);
    tick();
    reset = 1'b1;
    tick();

    // all addresses read zero on both ports
    for (int i = 0; i < 8; i++) begin
      rd_en_a = 1'b1; rd_addr_a = 3'(i);
      rd_en_b = 1'b1; rd_addr_b = 3'(7 - i);
      tick();
      check("init_rd_a", {15'd0, rd_valid_a, rd_data_a}, 32'h0001_0000);
      check("init_rd_b", {15'd0, rd_valid_b, rd_data_b}, 32'h0001_0000);
    end
    idle_inputs();
    tick();
    check("valid_drop_a", 32'(rd_valid_a), 32'h0);

    // byte-enabled writes
    write8(3'd3, 16'hA5A5, 2'b11);
    check("wr_ok_no_err", 32'(wr_err), 32'h0);
    write8(3'd3, 16'h1234, 2'b01);
    read_a(3'd3);
    check("be_merge_lo", 32'(rd_data_a), 32'h0000_A534);
    write8(3'd3, 16'hFFFF, 2'b00);
    check("be_zero_no_err", 32'(wr_err), 32'h0);
    read_a(3'd3);
    check("be_zero_noop", 32'(rd_data_a), 32'h0000_A534);
    write8(3'd3, 16'h5600, 2'b10);
    read_a(3'd3);
    check("be_merge_hi", 32'(rd_data_a), 32'h0000_5634);

    // write-first bypass on both ports, full word then one lane
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF; wr_be = 2'b11;
    rd_en_a = 1'b1; rd_addr_a = 3'd5; rd_en_b = 1'b1; rd_addr_b = 3'd5;
    tick();
    check("bypass_a", 32'(rd_data_a), 32'h0000_BEEF);
    check("bypass_b", 32'(rd_data_b), 32'h0000_BEEF);
    wr_data = 16'h1122; wr_be = 2'b01;
    tick();
    check("bypass_lane_a", 32'(rd_data_a), 32'h0000_BE22);
    idle_inputs();
    tick();
    check("hold_data_a", {15'd0, rd_valid_a, rd_data_a}, 32'h0000_BE22);

    write8(3'd7, 16'h7777, 2'b11);
    check("wr_addr7_no_err", 32'(wr_err), 32'h0);
    read_a(3'd7);
    check("rd_addr7", 32'(rd_data_a), 32'h0000_7777);

    // DEPTH=6 instance: out-of-range write rejected, out-of-range read is 0
    s6_wr_en = 1'b1; s6_wr_addr = 3'd5; s6_wr_data = 16'h5555;
    tick();
    check("d6_inrange_no_err", 32'(s6_wr_err), 32'h0);
    s6_wr_addr = 3'd6; s6_wr_data = 16'h6666;
    tick();
    check("d6_wr_err_pulse", 32'(s6_wr_err), 32'h1);
    s6_wr_en = 1'b0;
    tick();
    check("d6_wr_err_single", 32'(s6_wr_err), 32'h0);
    s6_rd_en = 1'b1; s6_rd_addr = 3'd6;
    tick();
    check("d6_oor_read", {15'd0, s6_rd_valid, s6_rd_data}, 32'h0001_0000);
    s6_rd_addr = 3'd5;
    tick();
    check("d6_unchanged", 32'(s6_rd_data), 32'h0000_5555);
    s6_rd_en = 1'b0;

    // fill, then sweep
    for (int i = 0; i < 8; i++) write8(3'(i), 16'hFFFF, 2'b11);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt = int'(busy);
    check("sweep_busy_rise", 32'(busy), 32'h1);
    rd_en_a = 1'b1; rd_addr_a = 3'd7; rd_en_b = 1'b1; rd_addr_b = 3'd0;
    tick();
    busy_cnt += int'(busy);
    check("sweep_not_yet_cleared", 32'(rd_data_a), 32'h0000_FFFF);
    check("sweep_clear_bypass", 32'(rd_data_b), 32'h0);
    rd_en_b = 1'b0;
    rd_addr_a = 3'd0;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234; wr_be = 2'b11;
    clr_req = 1'b1;
    tick();
    busy_cnt += int'(busy);
    check("sweep_wr_err", 32'(wr_err), 32'h1);
    check("sweep_already_cleared", 32'(rd_data_a), 32'h0);
    idle_inputs();
    tick();
    busy_cnt += int'(busy);
    check("sweep_wr_err_single", 32'(wr_err), 32'h0);
    for (int i = 0; i < 9; i++) begin
      tick();
      busy_cnt += int'(busy);
    end
    check("sweep_busy_cycles", 32'(busy_cnt), 32'd8);
    for (int i = 0; i < 8; i++) begin
      rd_en_a = 1'b1; rd_addr_a = 3'(i); rd_en_b = 1'b1; rd_addr_b = 3'(i);
      tick();
      check("post_sweep_a", 32'(rd_data_a), 32'h0);
      check("post_sweep_b", 32'(rd_data_b), 32'h0);
    end
    idle_inputs();

    // reset in the middle of a sweep
    write8(3'd4, 16'h4444, 2'b11);
    write8(3'd6, 16'h6666, 2'b11);
    read_a(3'd4);
    check("pre_reset_rd", 32'(rd_data_a), 32'h0000_4444);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("midsweep_reset_busy", 32'(busy), 32'h0);
    check("midsweep_reset_rd", {15'd0, rd_valid_a, rd_data_a}, 32'h0);
    check("midsweep_reset_err", 32'(wr_err), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    rd_en_a = 1'b1; rd_addr_a = 3'd4; rd_en_b = 1'b1; rd_addr_b = 3'd6;
    tick();
    check("reset_cleared_4", 32'(rd_data_a), 32'h0);
    check("reset_cleared_6", 32'(rd_data_b), 32'h0);
    idle_inputs();
    write8(3'd0, 16'h0A0A, 2'b11);
    write8(3'd7, 16'h7070, 2'b11);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("restart_busy", 32'(busy), 32'h1);
    rd_en_a = 1'b1; rd_addr_a = 3'd7; rd_en_b = 1'b1; rd_addr_b = 3'd0;
    tick();
    check("restart_ptr0_b", 32'(rd_data_b), 32'h0);
    check("restart_a_old", 32'(rd_data_a), 32'h0000_7070);
    idle_inputs();
    repeat (7) tick();
    check("restart_busy_drop", 32'(busy), 32'h0);
    read_a(3'd7);
    check("restart_cleared_7", 32'(rd_data_a), 32'h0);

`ifdef REGLOG_PARITY_EN
    par_inj = 1'b1;
    write8(3'd2, 16'h00FF, 2'b11);
    par_inj = 1'b0;
    read_a(3'd2);
    check("perr_injected", {15'd0, rd_perr_a, rd_data_a}, 32'h0001_00FF);
    write8(3'd2, 16'h00FF, 2'b11);
    read_a(3'd2);
    check("perr_clean", 32'(rd_perr_a), 32'h0);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0301; wr_be = 2'b11; par_inj = 1'b1;
    rd_en_b = 1'b1; rd_addr_b = 3'd1;
    tick();
    check("perr_bypass_inj", 32'(rd_perr_b), 32'h1);
    par_inj = 1'b0;
    tick();
    check("perr_bypass_clean", 32'(rd_perr_b), 32'h0);
    idle_inputs();
    tick();
    check("perr_idle", 32'(rd_perr_b), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reglog_bank.md
Name: reglog_bank

Overview:
- Parametrised successor to the team's small register-log file.
- Register array of DEPTH entries, DATA_W bits each.
- One byte-enabled write port and two independent read ports (A, B), both registered and write-first bypassed.
- A sequential clear-sweep FSM zeroes the array one entry per cycle.
- Sits beside the control datapath as general-purpose scratch/config storage.

Parameters:
- DATA_W, 16: register width in bits; must be a multiple of 8.
- DEPTH, 8: number of registers; 2..2**ADDR_W.
- ADDR_W, 3: address width.
- BE_W, DATA_W/8: byte-lane count; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- wr_en  input  1  write request
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- wr_be  input  BE_W  byte enables; bit k covers data[8k+7:8k]
- rd_en_a  input  1  port A read request
- rd_addr_a  input  ADDR_W  port A address
- rd_data_a  output  DATA_W  port A data
- rd_valid_a  output  1  port A data valid
- rd_en_b, rd_addr_b, rd_data_b, rd_valid_b: as port A, for port B
- clr_req  input  1  start clear sweep (sampled when idle)
- busy  output  1  sweep in progress
- wr_err  output  1  rejected-write pulse

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers 0.
  - rd_data_a/b = 0, rd_valid_a/b = 0, busy = 0, wr_err = 0.
  - FSM = IDLE, sweep pointer = 0.
  - Reset asserted mid-sweep aborts the sweep; the array ends all-zero either way.
- Write, accepted at a clk edge when wr_en=1, busy=0 and wr_addr<DEPTH:
  - Only lanes with wr_be[k]=1 are updated; other lanes hold.
  - wr_be=0 is a legal no-op with no error.
- Rejected write (wr_en=1 and (busy=1 or wr_addr>=DEPTH)):
  - Array unchanged.
  - wr_err=1 for exactly one cycle, on the edge after the request.
  - wr_err is 0 otherwise.
- Read, per port, with 1-cycle latency:
  - rd_en at edge N gives rd_data/rd_valid at edge N+1.
  - rd_valid = rd_en registered.
  - With rd_en=0, rd_data holds its last value.
- Read bypass and corner cases:
  - Same-cycle accepted write to the same address returns the merged new value (write-first, byte-granular).
  - Out-of-range read returns 0 with rd_valid=1.
  - Both ports may read the same address in the same cycle.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on clr_req=1; pointer = 0; busy goes 1 on that same edge.
  - In SWEEP, each edge clears entry[ptr] and increments ptr.
  - When ptr=DEPTH-1 has been cleared, the FSM returns to IDLE and busy drops on that edge. SWEEP lasts exactly DEPTH cycles.
  - clr_req while in SWEEP is ignored; there is no re-queue.
  - A write in the same cycle as clr_req (busy still 0) is accepted, then cleared later by the sweep.
- Reads during SWEEP are allowed:
  - Already-cleared entries read 0.
  - An entry being cleared in the read cycle reads 0 (clear bypass).
  - Not-yet-cleared entries return their old contents.
- Widths:
  - No arithmetic beyond the pointer increment; ptr is ADDR_W bits and never exceeds DEPTH-1.
  - Address comparison against DEPTH is unsigned.

Optional Feature:
- REGLOG_PARITY_EN defined:
  - One even-parity bit is stored per byte lane.
  - Each written lane's parity is computed on write.
  - Added input par_inj (1 bit): when 1 during an accepted write, the stored parity of the written lanes is inverted.
  - Added outputs rd_perr_a and rd_perr_b (1 bit each): asserted with rd_valid when any read lane's parity mismatches; 0 otherwise.
  - Sweep clears data and sets parity consistent with 0.
  - Bypassed reads use freshly computed parity, so they flag only if par_inj=1.
- REGLOG_PARITY_EN not defined: no parity storage, and ports par_inj/rd_perr_a/rd_perr_b are absent.

Test Plan:
- Reset, then read all 8 addresses on A and B -> each rd_data=0x0000, rd_valid=1 one cycle after each rd_en.
- Write 0xA5A5 to addr 3 with be=11, then be=01 with 0x1234 -> addr 3 reads 0xA534.
- Same cycle: write 0xBEEF to addr 5 with be=11, rd_en_a at addr 5 -> rd_data_a=0xBEEF next cycle. Write to addr 7 with wr_addr=7 valid; write with DEPTH=6 instance to addr 6 -> wr_err single-cycle pulse, array unchanged.
- Fill all entries with 0xFFFF, pulse clr_req, try a write at cycle 2 of the sweep -> busy high for exactly 8 cycles, wr_err pulse, all entries read 0 afterward. Read addr 7 at sweep cycle 1 -> 0xFFFF.
- Assert reset at sweep cycle 3 -> busy=0 and all outputs 0 immediately; a clr_req after release restarts the sweep from pointer 0.
- With REGLOG_PARITY_EN: write 0x00FF with par_inj=1 to addr 2, read -> rd_perr_a=1. Rewrite with par_inj=0 -> rd_perr_a=0.
